// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller states, the
// default operand width and the bit-counter width helper.
package bit_serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Counter needs $clog2(WIDTH) bits, but never fewer than one so WIDTH=1 still has a register.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// Single 1-bit full-adder slice; the controller time-multiplexes it over
// every operand bit.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic C
);

  logic halfSum;

  // Classic full adder: sum is the 3-way XOR, carry when two or more inputs are set.
  always_comb begin
    halfSum = A ^ B;
    S       = halfSum ^ CIN;
    C       = (A & B) | (CIN & halfSum);
  end

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder controller: accepts A, B, CIN with a valid/ready handshake,
// adds one bit per cycle LSB first through a single fa_cell, then holds
// {COUT,SUM} until the consumer takes it.
module bit_serial_adder_ctrl
  import bit_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
);

  localparam int                CNT_W    = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   aShift_q;
  logic [WIDTH-1:0]   bShift_q;
  logic               carry_q;
  logic [CNT_W-1:0]   bitCnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               outValid_q;
  logic               inReady_q;
  logic               busy_q;

  logic               sliceSum;
  logic               sliceCarry;

  // The operands are shifted right each RUN cycle, so bit 0 is always the bit being added.
  fa_cell u_fa_cell (
    .A   (aShift_q[0]),
    .B   (bShift_q[0]),
    .CIN (carry_q),
    .S   (sliceSum),
    .C   (sliceCarry)
  );

  // Controller FSM: owns operand shifters, carry, bit counter and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      carry_q    <= 1'b0;
      bitCnt_q   <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            aShift_q  <= A;
            bShift_q  <= B;
            carry_q   <= CIN;
            bitCnt_q  <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          sum_q[bitCnt_q] <= sliceSum;
          carry_q         <= sliceCarry;
          aShift_q        <= aShift_q >> 1;
          bShift_q        <= bShift_q >> 1;
          if (bitCnt_q == LAST_BIT) begin
            cout_q     <= sliceCarry;
            outValid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= HOLD;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = inReady_q;
  assign OUT_VALID = outValid_q;
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl: an 8-bit instance for the main
// scenarios and a 1-bit instance for the degenerate width.
module tb_bit_serial_adder_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       OUT_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic       CIN;
  logic       IN_READY;
  logic       OUT_VALID;
  logic [7:0] SUM;
  logic       COUT;
  logic       BUSY;

  logic       w1InValid;
  logic       w1OutReady;
  logic [0:0] w1A;
  logic [0:0] w1B;
  logic       w1Cin;
  logic       w1InReady;
  logic       w1OutValid;
  logic [0:0] w1Sum;
  logic       w1Cout;
  logic       w1Busy;

  int numCompared   = 0;
  int numMismatched = 0;

  // Free-running 10-time-unit clock; everything is driven and sampled on the falling edge.
  always #5 CLK = ~CLK;

  bit_serial_adder_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY)
  );

  bit_serial_adder_ctrl #(.WIDTH(1)) dutW1 (
    .CLK(CLK), .RST(RST), .IN_VALID(w1InValid), .IN_READY(w1InReady),
    .A(w1A), .B(w1B), .CIN(w1Cin), .OUT_VALID(w1OutValid), .OUT_READY(w1OutReady),
    .SUM(w1Sum), .COUT(w1Cout), .BUSY(w1Busy)
  );

  // Launches one op from IDLE on the 8-bit instance and returns the cycles until OUT_VALID.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               output int lat);
    A = a; B = b; CIN = cin; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b0; A = 8'hAA; B = 8'h55; CIN = 1'b1;
    w1InValid = 1'b1; w1OutReady = 1'b0; w1A = 1'b1; w1B = 1'b1; w1Cin = 1'b1;
    repeat (2) @(negedge CLK);
    numCompared++; if (SUM !== 8'h00) begin numMismatched++; $display("[TB] FAIL reset_sum: got %h expected 00", SUM); end
    numCompared++; if (COUT !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_cout: got %b expected 0", COUT); end
    numCompared++; if (OUT_VALID !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    numCompared++; if (BUSY !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    numCompared++; if (IN_READY !== 1'b1) begin numMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", IN_READY); end
    numCompared++; if (w1InReady !== 1'b1 || w1Busy !== 1'b0 || w1OutValid !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL reset_w1: got rdy=%b busy=%b ov=%b expected rdy=1 busy=0 ov=0", w1InReady, w1Busy, w1OutValid);
    end
    RST = 1'b0; IN_VALID = 1'b0; w1InValid = 1'b0;
    @(negedge CLK);
    numCompared++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL reset_release_idle: got rdy=%b busy=%b expected rdy=1 busy=0", IN_READY, BUSY);
    end
  endtask

  task automatic test_basic_add();
    int lat;
    A = 8'h03; B = 8'h05; CIN = 1'b0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    numCompared++; if (BUSY !== 1'b1 || IN_READY !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL basic_run_flags: got busy=%b rdy=%b expected busy=1 rdy=0", BUSY, IN_READY);
    end
    numCompared++; if (SUM !== 8'h00) begin numMismatched++; $display("[TB] FAIL basic_sum_cleared: got %h expected 00", SUM); end
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    numCompared++; if (lat != 8) begin numMismatched++; $display("[TB] FAIL basic_latency: got %0d expected 8", lat); end
    numCompared++; if (SUM !== 8'h08) begin numMismatched++; $display("[TB] FAIL basic_sum: got %h expected 08", SUM); end
    numCompared++; if (COUT !== 1'b0) begin numMismatched++; $display("[TB] FAIL basic_cout: got %b expected 0", COUT); end
    numCompared++; if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL basic_hold_flags: got busy=%b rdy=%b expected busy=0 rdy=0", BUSY, IN_READY);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    numCompared++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      numMismatched++; $display("[TB] FAIL basic_release: got ov=%b rdy=%b expected ov=0 rdy=1", OUT_VALID, IN_READY);
    end
  endtask

  task automatic test_carry_cases();
    int lat;
    applyStimulus(8'hFF, 8'h01, 1'b0, lat);
    numCompared++; if (lat != 8) begin numMismatched++; $display("[TB] FAIL carry1_latency: got %0d expected 8", lat); end
    numCompared++; if (SUM !== 8'h00 || COUT !== 1'b1) begin
      numMismatched++; $display("[TB] FAIL carry1_result: got cout=%b sum=%h expected cout=1 sum=00", COUT, SUM);
    end
    OUT_READY = 1'b1; @(negedge CLK); OUT_READY = 1'b0;
    applyStimulus(8'hFF, 8'h00, 1'b1, lat);
    numCompared++; if (lat != 8) begin numMismatched++; $display("[TB] FAIL carry2_latency: got %0d expected 8", lat); end
    numCompared++; if (SUM !== 8'h00 || COUT !== 1'b1) begin
      numMismatched++; $display("[TB] FAIL carry2_result: got cout=%b sum=%h expected cout=1 sum=00", COUT, SUM);
    end
    OUT_READY = 1'b1; @(negedge CLK); OUT_READY = 1'b0;
  endtask

  task automatic test_partial_sum();
    A = 8'hFF; B = 8'h00; CIN = 1'b0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    numCompared++; if (SUM !== 8'h01) begin numMismatched++; $display("[TB] FAIL partial_bit0: got %h expected 01", SUM); end
    repeat (2) @(negedge CLK);
    numCompared++; if (SUM !== 8'h07) begin numMismatched++; $display("[TB] FAIL partial_bit2: got %h expected 07", SUM); end
    repeat (5) @(negedge CLK);
    numCompared++; if (OUT_VALID !== 1'b1 || SUM !== 8'hFF || COUT !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL partial_final: got ov=%b cout=%b sum=%h expected ov=1 cout=0 sum=ff", OUT_VALID, COUT, SUM);
    end
    OUT_READY = 1'b1; @(negedge CLK); OUT_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    applyStimulus(8'h7A, 8'h9C, 1'b1, lat);
    numCompared++; if (lat != 8) begin numMismatched++; $display("[TB] FAIL bp_latency: got %0d expected 8", lat); end
    IN_VALID = 1'b1; A = 8'h11; B = 8'h22; CIN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      numCompared++; if (OUT_VALID !== 1'b1 || SUM !== 8'h17 || COUT !== 1'b1 || IN_READY !== 1'b0) begin
        numMismatched++;
        $display("[TB] FAIL bp_hold_%0d: got ov=%b cout=%b sum=%h rdy=%b expected ov=1 cout=1 sum=17 rdy=0", i, OUT_VALID, COUT, SUM, IN_READY);
      end
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    numCompared++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL bp_release: got ov=%b rdy=%b busy=%b expected ov=0 rdy=1 busy=0", OUT_VALID, IN_READY, BUSY);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    A = 8'h55; B = 8'h0F; CIN = 1'b1; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1; IN_VALID = 1'b1;
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0;
    numCompared++; if (SUM !== 8'h00 || COUT !== 1'b0 || OUT_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL midrst_state: got sum=%h cout=%b ov=%b busy=%b rdy=%b expected sum=00 cout=0 ov=0 busy=0 rdy=1", SUM, COUT, OUT_VALID, BUSY, IN_READY);
    end
    repeat (10) @(negedge CLK);
    numCompared++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL midrst_no_result: got ov=%b busy=%b expected ov=0 busy=0", OUT_VALID, BUSY);
    end
    applyStimulus(8'h10, 8'h20, 1'b0, lat);
    numCompared++; if (lat != 8 || SUM !== 8'h30 || COUT !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL midrst_next_op: got lat=%0d cout=%b sum=%h expected lat=8 cout=0 sum=30", lat, COUT, SUM);
    end
    OUT_READY = 1'b1; @(negedge CLK); OUT_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] expTotal;
    int         lat;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    for (int op = 0; op < 100; op++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      expTotal = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      A = a; B = b; CIN = cin;
      @(negedge CLK);
      numCompared++; if (IN_READY !== 1'b0 || BUSY !== 1'b1) begin
        numMismatched++; $display("[TB] FAIL b2b_accept_%0d: got rdy=%b busy=%b expected rdy=0 busy=1", op, IN_READY, BUSY);
      end
      A = ~a; B = 8'($urandom); CIN = ~cin;
      lat = 0;
      while (OUT_VALID !== 1'b1 && lat < 40) begin
        @(negedge CLK);
        lat++;
      end
      numCompared++; if (lat != 8) begin numMismatched++; $display("[TB] FAIL b2b_latency_%0d: got %0d expected 8", op, lat); end
      numCompared++; if ({COUT, SUM} !== expTotal) begin
        numMismatched++; $display("[TB] FAIL b2b_result_%0d: got %h expected %h (a=%h b=%h cin=%b)", op, {COUT, SUM}, expTotal, a, b, cin);
      end
      @(negedge CLK);
      numCompared++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
        numMismatched++; $display("[TB] FAIL b2b_idle_%0d: got ov=%b rdy=%b expected ov=0 rdy=1", op, OUT_VALID, IN_READY);
      end
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_width1();
    w1A = 1'b1; w1B = 1'b1; w1Cin = 1'b1; w1InValid = 1'b1;
    @(negedge CLK);
    w1InValid = 1'b0;
    numCompared++; if (w1Busy !== 1'b1 || w1InReady !== 1'b0 || w1OutValid !== 1'b0) begin
      numMismatched++; $display("[TB] FAIL w1_run: got busy=%b rdy=%b ov=%b expected busy=1 rdy=0 ov=0", w1Busy, w1InReady, w1OutValid);
    end
    @(negedge CLK);
    numCompared++; if (w1OutValid !== 1'b1 || w1Sum !== 1'b1 || w1Cout !== 1'b1) begin
      numMismatched++; $display("[TB] FAIL w1_result: got ov=%b sum=%b cout=%b expected ov=1 sum=1 cout=1", w1OutValid, w1Sum, w1Cout);
    end
    w1OutReady = 1'b1;
    @(negedge CLK);
    w1OutReady = 1'b0;
    numCompared++; if (w1OutValid !== 1'b0 || w1InReady !== 1'b1) begin
      numMismatched++; $display("[TB] FAIL w1_release: got ov=%b rdy=%b expected ov=0 rdy=1", w1OutValid, w1InReady);
    end
  endtask

  // Runs every scenario in order, then prints the one-line summary.
  initial begin
    @(negedge CLK);
    test_reset();
    test_basic_add();
    test_carry_cases();
    test_partial_sum();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
